sparc_exu_wb_pipe: RTL and testbench

Write-back pipeline feeding the EXU per-thread state register. It captures a register-write request in E, carries it through M and W, and applies stall, kill and flush. At W it drives the register's write port (wen_w, thr_w, data_in_w). It also supplies a bypassed read value so consumers see in-flight writes before they land.

---
 rtl/sparc_exu_pipe_pkg.sv | 21 ++
 rtl/sparc_exu_wb_stg.sv | 34 +++
 rtl/sparc_exu_wb_pipe.sv | 86 ++++++++
 tb/tb_sparc_exu_wb_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sparc_exu_pipe_pkg.sv
// Shared constants, stage record and thread-match helper for the EXU
// write-back pipeline.
package sparc_exu_pipe_pkg;

    localparam int NTHR    = 4;
    localparam int SIZE    = 3;
    localparam int THR_MAX = 32;

    typedef struct packed {
        logic            vld;
        logic [NTHR-1:0] thr;
        logic [SIZE-1:0] data;
    } stg_t;

    // Width-agnostic one-hot overlap test; callers zero-extend to THR_MAX.
    function automatic logic thr_match(input logic [THR_MAX-1:0] a,
                                       input logic [THR_MAX-1:0] b);
        return |(a & b);
    endfunction

endpackage

// File: rtl/sparc_exu_wb_stg.sv
// One pipeline stage register {vld, thr, data} with hold, valid-clear and
// asynchronous active-low reset.
module sparc_exu_wb_stg #(
    parameter int SIZE = 3,
    parameter int NTHR = 4
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            hold,
    input  logic            clr,
    input  logic            d_vld,
    input  logic [NTHR-1:0] d_thr,
    input  logic [SIZE-1:0] d_data,
    output logic            q_vld,
    output logic [NTHR-1:0] q_thr,
    output logic [SIZE-1:0] q_data
);

    // clr only ever drops the valid bit; payload is don't-care once invalid.
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            q_vld  <= 1'b0;
            q_thr  <= '0;
            q_data <= '0;
        end else if (hold) begin
            q_vld  <= q_vld & ~clr;
        end else begin
            q_vld  <= d_vld & ~clr;
            q_thr  <= d_thr;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/sparc_exu_wb_pipe.sv
// E->M->W write-back pipe for the EXU per-thread state register, with
// stall/flush/kill handling and a youngest-first read bypass.
module sparc_exu_wb_pipe
    import sparc_exu_pipe_pkg::*;
#(
    parameter int SIZE = 3,
    parameter int NTHR = 4
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic            se,
    input  logic            wen_e,
    input  logic [NTHR-1:0] thr_e,
    input  logic [SIZE-1:0] data_e,
    input  logic            stall,
    input  logic            flush,
    input  logic            kill_m,
    input  logic            kill_w,
    input  logic [NTHR-1:0] thr_out,
    input  logic [SIZE-1:0] reg_data,
    output logic            wen_w,
    output logic [NTHR-1:0] thr_w,
    output logic [SIZE-1:0] data_in_w,
    output logic [SIZE-1:0] byp_data,
    output logic            byp_hit,
    output logic            busy
);

    logic            m_vld, w_vld;
    logic [NTHR-1:0] m_thr, w_thr;
    logic [SIZE-1:0] m_data, w_data;
    logic            e_vld, w_clr;
    logic            m_hit, w_hit;

    wire unused_se = se;

    assign e_vld = wen_e & (|thr_e);
    // While stalled W holds, so only kill_w can retire it; otherwise W takes M.
    assign w_clr = stall ? kill_w : (flush | kill_m);

    sparc_exu_wb_stg #(.SIZE(SIZE), .NTHR(NTHR)) u_stg_m (
        .clk    (clk),
        .arst_l (arst_l),
        .hold   (stall),
        .clr    (flush),
        .d_vld  (e_vld),
        .d_thr  (thr_e),
        .d_data (data_e),
        .q_vld  (m_vld),
        .q_thr  (m_thr),
        .q_data (m_data)
    );

    sparc_exu_wb_stg #(.SIZE(SIZE), .NTHR(NTHR)) u_stg_w (
        .clk    (clk),
        .arst_l (arst_l),
        .hold   (stall),
        .clr    (w_clr),
        .d_vld  (m_vld),
        .d_thr  (m_thr),
        .d_data (m_data),
        .q_vld  (w_vld),
        .q_thr  (w_thr),
        .q_data (w_data)
    );

    assign wen_w     = w_vld & ~kill_w & ~stall;
    assign thr_w     = w_vld ? w_thr  : '0;
    assign data_in_w = w_vld ? w_data : '0;

    // M is younger than W, so it takes priority on a thread match.
    assign m_hit = m_vld & thr_match(THR_MAX'(m_thr), THR_MAX'(thr_out));
    assign w_hit = w_vld & ~kill_w & thr_match(THR_MAX'(w_thr), THR_MAX'(thr_out));

    always_comb begin
        byp_data = reg_data;
        if (m_hit)
            byp_data = m_data;
        else if (w_hit)
            byp_data = w_data;
    end

    assign byp_hit = m_hit | w_hit;
    assign busy    = m_vld | w_vld;

endmodule

// File: tb/tb_sparc_exu_wb_pipe.sv
// Directed-vector bench for sparc_exu_wb_pipe with a small downstream
// per-thread register model closing the write/read loop.
module tb_sparc_exu_wb_pipe;

    logic       clk = 1'b0;
    logic       arst_l, se, wen_e, stall, flush, kill_m, kill_w;
    logic [3:0] thr_e, thr_out, thr_w;
    logic [2:0] data_e, reg_data, data_in_w, byp_data;
    logic       wen_w, byp_hit, busy;
    logic [2:0] regs [4];

    int n_chk = 0;
    int n_err = 0;

    sparc_exu_wb_pipe #(.SIZE(3), .NTHR(4)) dut (
        .clk       (clk),
        .arst_l    (arst_l),
        .se        (se),
        .wen_e     (wen_e),
        .thr_e     (thr_e),
        .data_e    (data_e),
        .stall     (stall),
        .flush     (flush),
        .kill_m    (kill_m),
        .kill_w    (kill_w),
        .thr_out   (thr_out),
        .reg_data  (reg_data),
        .wen_w     (wen_w),
        .thr_w     (thr_w),
        .data_in_w (data_in_w),
        .byp_data  (byp_data),
        .byp_hit   (byp_hit),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Downstream register: one entry per thread, written at the W edge.
    always @(posedge clk)
        if (wen_w)
            for (int i = 0; i < 4; i++)
                if (thr_w[i]) regs[i] <= data_in_w;

    always_comb begin
        reg_data = '0;
        for (int i = 0; i < 4; i++)
            if (thr_out[i]) reg_data = regs[i];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to the next cycle; inputs are then set and outputs checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] t, input logic [2:0] d);
        wen_e  = 1'b1;
        thr_e  = t;
        data_e = d;
    endtask

    task automatic idle();
        wen_e  = 1'b0;
        thr_e  = '0;
        data_e = '0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) regs[i] = 3'b101;
        arst_l = 1'b0; se = 1'b0; stall = 1'b0; flush = 1'b0;
        kill_m = 1'b0; kill_w = 1'b0; thr_out = 4'b0001;
        idle();
        #12 arst_l = 1'b1;
        #1;
        chk("rst_wen",   32'(wen_w), 0);
        chk("rst_thr",   32'(thr_w), 0);
        chk("rst_data",  32'(data_in_w), 0);
        chk("rst_hit",   32'(byp_hit), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_byp",   32'(byp_data), 5);

        // Single write, thread 0
        tick(); req(4'b0001, 3'b110);
        tick(); idle(); #1;
        chk("t1_c1_hit",  32'(byp_hit), 1);
        chk("t1_c1_byp",  32'(byp_data), 6);
        chk("t1_c1_wen",  32'(wen_w), 0);
        tick(); #1;
        chk("t1_c2_wen",  32'(wen_w), 1);
        chk("t1_c2_thr",  32'(thr_w), 1);
        chk("t1_c2_data", 32'(data_in_w), 6);
        tick(); #1;
        chk("t1_c3_busy", 32'(busy), 0);
        chk("t1_c3_hit",  32'(byp_hit), 0);
        chk("t1_c3_byp",  32'(byp_data), 6);

        // Back-to-back same-thread writes
        tick(); req(4'b0001, 3'b001);
        tick(); req(4'b0001, 3'b010); #1;
        chk("t2_c1_byp",  32'(byp_data), 1);
        tick(); idle(); #1;
        chk("t2_c2_byp",  32'(byp_data), 2);
        chk("t2_c2_wen",  32'(wen_w), 1);
        chk("t2_c2_data", 32'(data_in_w), 1);
        tick(); #1;
        chk("t2_c3_wen",  32'(wen_w), 1);
        chk("t2_c3_data", 32'(data_in_w), 2);
        tick(); #1;
        chk("t2_c4_wen",  32'(wen_w), 0);
        chk("t2_c4_byp",  32'(byp_data), 2);

        // kill_m discards the M entry
        tick(); req(4'b0001, 3'b011);
        tick(); idle(); kill_m = 1'b1; #1;
        chk("t3_c1_busy", 32'(busy), 1);
        tick(); kill_m = 1'b0; #1;
        chk("t3_c2_wen",  32'(wen_w), 0);
        chk("t3_c2_busy", 32'(busy), 0);
        chk("t3_c2_byp",  32'(byp_data), 2);

        // All-zero thread select is a no-op
        tick(); req(4'b0000, 3'b111);
        tick(); idle(); #1;
        chk("t4_busy",    32'(busy), 0);

        // Stall holds W; requests during stall are dropped
        thr_out = 4'b0010;
        tick(); req(4'b0010, 3'b100);
        tick(); idle();
        tick(); stall = 1'b1; req(4'b0010, 3'b111); #1;
        chk("t5_c2_wen",  32'(wen_w), 0);
        chk("t5_c2_busy", 32'(busy), 1);
        chk("t5_c2_byp",  32'(byp_data), 4);
        chk("t5_c2_data", 32'(data_in_w), 4);
        tick(); #1;
        chk("t5_c3_wen",  32'(wen_w), 0);
        chk("t5_c3_byp",  32'(byp_data), 4);
        tick(); stall = 1'b0; idle(); #1;
        chk("t5_c4_wen",  32'(wen_w), 1);
        chk("t5_c4_thr",  32'(thr_w), 2);
        chk("t5_c4_data", 32'(data_in_w), 4);
        chk("t5_c4_byp",  32'(byp_data), 4);
        tick(); #1;
        chk("t5_c5_wen",  32'(wen_w), 0);
        chk("t5_c5_busy", 32'(busy), 0);
        tick(); #1;
        chk("t5_reg",     32'(regs[1]), 4);

        // flush clears M and the E capture
        thr_out = 4'b0100;
        tick(); req(4'b0100, 3'b001);
        tick(); flush = 1'b1; req(4'b0100, 3'b010); #1;
        chk("t6_c1_hit",  32'(byp_hit), 1);
        tick(); flush = 1'b0; idle(); #1;
        chk("t6_c2_busy", 32'(busy), 0);
        chk("t6_c2_wen",  32'(wen_w), 0);

        // kill_w suppresses the write and the W bypass
        tick(); req(4'b0100, 3'b110);
        tick(); idle();
        tick(); kill_w = 1'b1; #1;
        chk("t7_c2_wen",  32'(wen_w), 0);
        chk("t7_c2_hit",  32'(byp_hit), 0);
        chk("t7_c2_byp",  32'(byp_data), 5);
        chk("t7_c2_thr",  32'(thr_w), 4);
        tick(); kill_w = 1'b0; #1;
        chk("t7_c3_busy", 32'(busy), 0);
        chk("t7_reg",     32'(regs[2]), 5);

        // stall together with kill_w clears W without writing
        tick(); req(4'b0100, 3'b011);
        tick(); idle();
        tick(); stall = 1'b1; kill_w = 1'b1; #1;
        chk("t8_c2_wen",  32'(wen_w), 0);
        tick(); stall = 1'b0; kill_w = 1'b0; #1;
        chk("t8_c3_wen",  32'(wen_w), 0);
        chk("t8_c3_busy", 32'(busy), 0);
        tick(); #1;
        chk("t8_reg",     32'(regs[2]), 5);

        // Async reset mid-cycle discards M and W
        thr_out = 4'b1000;
        tick(); req(4'b1000, 3'b111);
        tick(); req(4'b1000, 3'b011);
        tick(); idle(); #1;
        chk("t9_pre_wen",  32'(wen_w), 1);
        chk("t9_pre_busy", 32'(busy), 1);
        #1 arst_l = 1'b0;
        #1;
        chk("t9_rst_wen",  32'(wen_w), 0);
        chk("t9_rst_busy", 32'(busy), 0);
        chk("t9_rst_hit",  32'(byp_hit), 0);
        chk("t9_rst_byp",  32'(byp_data), 5);
        #1 arst_l = 1'b1;
        tick(); #1;
        chk("t9_post_wen", 32'(wen_w), 0);
        tick(); tick(); #1;
        chk("t9_reg",      32'(regs[3]), 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
